// File: rtl/derandomizer_pkg.sv
// -----------------------------------------------------------------------------
// derandomizer_pkg
// Shared constants and types for the receive-side Gold-sequence derandomizer:
// LFSR width and load values, feedback/output tap masks, rotation codes and
// the framing FSM states.
// -----------------------------------------------------------------------------
package derandomizer_pkg;

  localparam int LFSR_W = 18;
  localparam int CNT_W  = 16;

  // y register always reloads to all ones; x load value is a parameter
  localparam logic [LFSR_W-1:0] Y_INIT = 18'h3FFFF;

  // Feedback taps: x uses x7^x0, y uses y10^y7^y5^y0
  localparam logic [LFSR_W-1:0] X_FB_TAPS = 18'h00081;
  localparam logic [LFSR_W-1:0] Y_FB_TAPS = 18'h004A1;

  // Output taps for the rotation MSB: z1 = x4^x6^x15, z2 = y[15:5] without y7
  localparam logic [LFSR_W-1:0] Z1_TAPS = 18'h08050;
  localparam logic [LFSR_W-1:0] Z2_TAPS = 18'h0FF60;

  typedef enum logic [1:0] {
    ROT_0   = 2'd0,
    ROT_90  = 2'd1,
    ROT_180 = 2'd2,
    ROT_270 = 2'd3
  } rot_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // XOR of the register bits selected by a tap mask
  function automatic logic tap_parity(input logic [LFSR_W-1:0] value,
                                      input logic [LFSR_W-1:0] taps);
    return ^(value & taps);
  endfunction

endpackage

// File: rtl/derandomizer_if.sv
// -----------------------------------------------------------------------------
// derandomizer_if
// Streaming bus around the derandomizer.
//   in_*  : received symbol stream (valid/ready, sof, I/Q)
//   out_* : derotated symbol stream (valid/ready, sof, eof, I/Q)
//   err   : one-cycle framing error pulse
// Modports: master = symbol source / sink side, slave = the derandomizer.
// -----------------------------------------------------------------------------
interface derandomizer_if #(
  parameter int W = 8
);

  logic                in_valid;
  logic                in_ready;
  logic                in_sof;
  logic signed [W-1:0] in_i;
  logic signed [W-1:0] in_q;

  logic                out_valid;
  logic                out_ready;
  logic                out_sof;
  logic                out_eof;
  logic signed [W-1:0] out_i;
  logic signed [W-1:0] out_q;

  logic                err;

  modport master (
    output in_valid, in_sof, in_i, in_q, out_ready,
    input  in_ready, out_valid, out_sof, out_eof, out_i, out_q, err
  );

  modport slave (
    input  in_valid, in_sof, in_i, in_q, out_ready,
    output in_ready, out_valid, out_sof, out_eof, out_i, out_q, err
  );

endinterface

// File: rtl/derandomizer_gold_seq_gen.sv
// -----------------------------------------------------------------------------
// gold_seq_gen
// Regenerates the 18-bit x/y Gold sequence and presents the 2-bit rotation
// index R for the current symbol.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_load         : use the INIT state for this symbol (frame start)
//   i_step         : advance the sequence by one symbol
//   o_r[1:0]       : rotation index of the effective (loaded or current) state
// -----------------------------------------------------------------------------
module gold_seq_gen
  import derandomizer_pkg::*;
#(
  parameter logic [LFSR_W-1:0] X_INIT = 18'h00001
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic       i_step,
  output logic [1:0] o_r
);

  logic [LFSR_W-1:0] x;
  logic [LFSR_W-1:0] y;
  logic [LFSR_W-1:0] x_eff;
  logic [LFSR_W-1:0] y_eff;

  // A load overrides the stored state for the current symbol, so a frame
  // start both uses INIT and steps from INIT in the same cycle.
  always_comb begin
    x_eff = i_load ? X_INIT : x;
    y_eff = i_load ? Y_INIT : y;
  end

  assign o_r = {tap_parity(x_eff, Z1_TAPS) ^ tap_parity(y_eff, Z2_TAPS),
                x_eff[0] ^ y_eff[0]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      x <= X_INIT;
      y <= Y_INIT;
    end else if (i_step) begin
      x <= {tap_parity(x_eff, X_FB_TAPS), x_eff[LFSR_W-1:1]};
      y <= {tap_parity(y_eff, Y_FB_TAPS), y_eff[LFSR_W-1:1]};
    end else if (i_load) begin
      x <= X_INIT;
      y <= Y_INIT;
    end
  end

endmodule

// File: rtl/derandomizer.sv
// -----------------------------------------------------------------------------
// derandomizer
// Receive-side inverse of the Gold-sequence PL scrambler. Each forwarded
// symbol is derotated by exp(-j*R*pi/2) using the regenerated sequence, and
// frames are tracked from sof plus a symbol counter.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus (slave)    : in_* input stream, out_* output stream, err pulse
// -----------------------------------------------------------------------------
module derandomizer
  import derandomizer_pkg::*;
#(
  parameter int                W         = 8,
  parameter int                FRAME_LEN = 1024,
  parameter logic [LFSR_W-1:0] X_INIT    = 18'h00001
) (
  input logic           i_clk,
  input logic           i_reset,
  derandomizer_if.slave bus
);

  localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic [CNT_W-1:0]    LAST    = CNT_W'(FRAME_LEN);

  state_e              state;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_next;
  logic                accept;
  logic                forward;
  logic                frame_err;
  logic                last;
  logic [1:0]          r;
  logic signed [W-1:0] rot_i;
  logic signed [W-1:0] rot_q;

  // The most negative sample has no positive counterpart; clamp it.
  function automatic logic signed [W-1:0] sat_neg(input logic signed [W-1:0] v);
    if (v == MIN_VAL) begin
      return MAX_VAL;
    end
    return -v;
  endfunction

  // Single output stage: a new beat is taken whenever the held one leaves.
  assign bus.in_ready = !bus.out_valid | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign forward      = accept & (bus.in_sof | (state == ACTIVE));
  assign frame_err    = accept & (bus.in_sof == (state == ACTIVE));
  assign count_next   = bus.in_sof ? CNT_W'(1) : count + CNT_W'(1);
  assign last         = (count_next == LAST);

  gold_seq_gen #(
    .X_INIT (X_INIT)
  ) u_gold_seq_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (accept & bus.in_sof),
    .i_step  (forward),
    .o_r     (r)
  );

  // Derotation by exp(-j*R*pi/2)
  always_comb begin
    rot_i = bus.in_i;
    rot_q = bus.in_q;
    case (rot_e'(r))
      ROT_0: begin
        rot_i = bus.in_i;
        rot_q = bus.in_q;
      end
      ROT_90: begin
        rot_i = bus.in_q;
        rot_q = sat_neg(bus.in_i);
      end
      ROT_180: begin
        rot_i = sat_neg(bus.in_i);
        rot_q = sat_neg(bus.in_q);
      end
      ROT_270: begin
        rot_i = sat_neg(bus.in_q);
        rot_q = bus.in_i;
      end
      default: begin
        rot_i = bus.in_i;
        rot_q = bus.in_q;
      end
    endcase
  end

  // Framing FSM and output register. A sof always starts a new frame, even
  // mid-frame (flagged as an error); beats outside a frame are dropped.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      count         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_i     <= '0;
      bus.out_q     <= '0;
      bus.out_sof   <= 1'b0;
      bus.out_eof   <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.err <= frame_err;
      if (forward) begin
        bus.out_valid <= 1'b1;
        bus.out_i     <= rot_i;
        bus.out_q     <= rot_q;
        bus.out_sof   <= bus.in_sof;
        bus.out_eof   <= last;
        if (last) begin
          state <= IDLE;
          count <= '0;
        end else begin
          state <= ACTIVE;
          count <= count_next;
        end
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_derandomizer.sv
// -----------------------------------------------------------------------------
// tb_derandomizer
// Directed bench for the derandomizer. A main instance uses 16-symbol frames;
// a second instance with 24-symbol frames shares the input stream so that the
// sequence reaches an R=2 symbol used for the saturation case.
// -----------------------------------------------------------------------------
module tb_derandomizer;

  localparam int W         = 8;
  localparam int FRAME_LEN = 16;
  localparam int LONG_LEN  = 24;
  localparam int SAT_MAX   = (1 << (W - 1)) - 1;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  int model_r [0:LONG_LEN-1];
  int sym_i   [0:LONG_LEN-1];
  int sym_q   [0:LONG_LEN-1];

  always #5 clk = ~clk;

  derandomizer_if #(.W(W)) bus ();
  derandomizer_if #(.W(W)) bus_long ();

  // Long instance mirrors the main input stream and never stalls
  assign bus_long.in_valid  = bus.in_valid;
  assign bus_long.in_sof    = bus.in_sof;
  assign bus_long.in_i      = bus.in_i;
  assign bus_long.in_q      = bus.in_q;
  assign bus_long.out_ready = 1'b1;

  derandomizer #(
    .W         (W),
    .FRAME_LEN (FRAME_LEN),
    .X_INIT    (18'h00001)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus.slave)
  );

  derandomizer #(
    .W         (W),
    .FRAME_LEN (LONG_LEN),
    .X_INIT    (18'h00001)
  ) dut_long (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus_long.slave)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Gold sequence as bit streams: s(k+18)=s(k+7)^s(k), u(k+18)=u(k+10)^u(k+7)^u(k+5)^u(k)
  function automatic void buildModel();
    bit s [0:63];
    bit u [0:63];
    bit z;
    for (int t = 0; t < 18; t++) begin
      s[t] = (t == 0);
      u[t] = 1'b1;
    end
    for (int k = 0; k < 46; k++) begin
      s[k+18] = s[k+7] ^ s[k];
      u[k+18] = u[k+10] ^ u[k+7] ^ u[k+5] ^ u[k];
    end
    for (int t = 0; t < LONG_LEN; t++) begin
      z = s[t+4] ^ s[t+6] ^ s[t+15];
      for (int j = 5; j <= 15; j++) begin
        if (j != 7) z ^= u[t+j];
      end
      model_r[t] = 2 * int'(z) + int'(s[t] ^ u[t]);
    end
  endfunction

  function automatic int clampPos(input int v);
    return (v > SAT_MAX) ? SAT_MAX : v;
  endfunction

  function automatic int expI(input int r, input int ii, input int qq);
    case (r)
      0:       return ii;
      1:       return qq;
      2:       return clampPos(-ii);
      default: return clampPos(-qq);
    endcase
  endfunction

  function automatic int expQ(input int r, input int ii, input int qq);
    case (r)
      0:       return qq;
      1:       return clampPos(-ii);
      2:       return clampPos(-qq);
      default: return ii;
    endcase
  endfunction

  // Drive one beat at a negedge, let the posedge take it, return at the next negedge
  task automatic applyStimulus(input bit v, input bit s, input int ii, input int qq);
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_i     = ii[W-1:0];
    bus.in_q     = qq[W-1:0];
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic checkSym(input string tag, input int k);
    checkOutput($sformatf("%s%0d_v", tag, k), bus.out_valid, 1);
    checkOutput($sformatf("%s%0d_i", tag, k), bus.out_i, expI(model_r[k], sym_i[k], sym_q[k]));
    checkOutput($sformatf("%s%0d_q", tag, k), bus.out_q, expQ(model_r[k], sym_i[k], sym_q[k]));
    checkOutput($sformatf("%s%0d_eof", tag, k), bus.out_eof, int'(k == FRAME_LEN - 1));
  endtask

  task automatic runFrame(input string tag);
    for (int k = 0; k < FRAME_LEN; k++) begin
      applyStimulus(1'b1, k == 0, sym_i[k], sym_q[k]);
      checkSym(tag, k);
      checkOutput($sformatf("%s%0d_sof", tag, k), bus.out_sof, int'(k == 0));
    end
  endtask

  initial begin
    int  sent;
    int  got;
    bit  stalled;
    int  prev_i;
    int  prev_q;

    buildModel();
    for (int k = 0; k < LONG_LEN; k++) begin
      sym_i[k] = int'($urandom_range(0, 255)) - 128;
      sym_q[k] = int'($urandom_range(0, 255)) - 128;
    end
    sym_i[0]  = 100;  sym_q[0]  = 20;
    sym_i[1]  = 100;  sym_q[1]  = 20;
    sym_i[19] = -128; sym_q[19] = -128;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_i      = '0;
    bus.in_q      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", bus.out_valid, 0);
    checkOutput("rst_i", bus.out_i, 0);
    checkOutput("rst_q", bus.out_q, 0);
    checkOutput("rst_sof", bus.out_sof, 0);
    checkOutput("rst_eof", bus.out_eof, 0);
    checkOutput("rst_err", bus.err, 0);
    reset = 1'b0;

    // First frame: two directed beats, then the rest of the frame
    applyStimulus(1'b1, 1'b1, 100, 20);
    checkOutput("first_valid", bus.out_valid, 1);
    checkOutput("first_i", bus.out_i, 100);
    checkOutput("first_q", bus.out_q, 20);
    checkOutput("first_sof", bus.out_sof, 1);
    applyStimulus(1'b1, 1'b0, 100, 20);
    checkOutput("second_i", bus.out_i, 20);
    checkOutput("second_q", bus.out_q, -100);
    checkOutput("second_sof", bus.out_sof, 0);
    for (int k = 2; k < FRAME_LEN; k++) begin
      applyStimulus(1'b1, 1'b0, sym_i[k], sym_q[k]);
      checkSym("f1_", k);
    end

    // Back in IDLE: beats without sof are dropped with an error each
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b1, 1'b0, 5, 5);
      checkOutput("drop_valid", bus.out_valid, 0);
      checkOutput("drop_err", bus.err, 1);
    end
    applyStimulus(1'b0, 1'b0, 0, 0);
    checkOutput("drop_err_clear", bus.err, 0);

    // Restart: sof on the fifth symbol of a frame
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, k == 0, sym_i[k], sym_q[k]);
      checkSym("pre_", k);
      checkOutput("pre_err", bus.err, 0);
    end
    applyStimulus(1'b1, 1'b1, sym_i[0], sym_q[0]);
    checkOutput("rs_err", bus.err, 1);
    checkOutput("rs_sof", bus.out_sof, 1);
    checkSym("rs_", 0);
    for (int k = 1; k < FRAME_LEN; k++) begin
      applyStimulus(1'b1, 1'b0, sym_i[k], sym_q[k]);
      checkSym("rs_", k);
    end

    // Back-to-back frame start without a bubble
    applyStimulus(1'b1, 1'b1, sym_i[0], sym_q[0]);
    checkOutput("b2b_sof", bus.out_sof, 1);
    checkOutput("b2b_err", bus.err, 0);
    checkSym("b2b_", 0);
    applyStimulus(1'b1, 1'b0, sym_i[1], sym_q[1]);
    checkSym("b2b_", 1);

    // Reset mid-frame discards the held symbol; next frame starts clean
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_valid", bus.out_valid, 0);
    runFrame("rf_");
    applyStimulus(1'b0, 1'b0, 0, 0);

    // Random downstream backpressure over one frame
    sent    = 0;
    got     = 0;
    stalled = 1'b0;
    prev_i  = 0;
    prev_q  = 0;
    for (int cyc = 0; cyc < 400 && got < FRAME_LEN; cyc++) begin
      if (stalled) begin
        checkOutput("bp_hold_valid", bus.out_valid, 1);
        checkOutput("bp_hold_i", bus.out_i, prev_i);
        checkOutput("bp_hold_q", bus.out_q, prev_q);
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        checkSym("bp_", got);
        got++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      prev_i  = bus.out_i;
      prev_q  = bus.out_q;
      if (sent < FRAME_LEN && bus.in_ready) begin
        bus.in_valid = 1'b1;
        bus.in_sof   = (sent == 0);
        bus.in_i     = sym_i[sent][W-1:0];
        bus.in_q     = sym_q[sent][W-1:0];
        sent++;
      end else begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput("bp_count", got, FRAME_LEN);
    applyStimulus(1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 0, 0);
    checkOutput("bp_tail_valid", bus.out_valid, 0);

    // Long frame on both instances; main drops the surplus beats
    for (int k = 0; k < LONG_LEN; k++) begin
      applyStimulus(1'b1, k == 0, sym_i[k], sym_q[k]);
      checkOutput($sformatf("long%0d_v", k), bus_long.out_valid, 1);
      checkOutput($sformatf("long%0d_i", k), bus_long.out_i, expI(model_r[k], sym_i[k], sym_q[k]));
      checkOutput($sformatf("long%0d_q", k), bus_long.out_q, expQ(model_r[k], sym_i[k], sym_q[k]));
      checkOutput($sformatf("long%0d_eof", k), bus_long.out_eof, int'(k == LONG_LEN - 1));
      if (k < FRAME_LEN) begin
        checkSym("main_", k);
      end else begin
        checkOutput("main_surplus_valid", bus.out_valid, 0);
        checkOutput("main_surplus_err", bus.err, 1);
      end
      if (k == 19) begin
        checkOutput("sat_r2_i", bus_long.out_i, 127);
        checkOutput("sat_r2_q", bus_long.out_q, 127);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
